// File: rtl/alu_sequencer.sv
// alu_sequencer: eight-phase instruction controller for the 8-bit accumulator CPU.
// Each 2-byte instruction passes through phases 0..7. The strobe row for the
// current phase is decoded from opcode/zero and registered on the rising edge.
// HLT latches a sticky halted state that only reset can clear.
module alu_sequencer #(
    parameter int unsigned PHASES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       alu_ena,
    output logic       load_acc,
    output logic       datactl_ena,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        OP_HLT  = 3'b000,
        OP_SKZ  = 3'b001,
        OP_ADD  = 3'b010,
        OP_ANDD = 3'b011,
        OP_XORR = 3'b100,
        OP_LDA  = 3'b101,
        OP_STO  = 3'b110,
        OP_JMP  = 3'b111
    } opcode_e;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_e;

    state_e     r_state;
    logic [2:0] r_phase;
    logic       r_rd, r_wr, r_load_ir, r_inc_pc, r_load_pc;
    logic       r_alu_ena, r_load_acc, r_datactl_ena, r_halt;

    opcode_e    w_op;
    logic       w_mem_op;
    logic       w_rd, w_wr, w_load_ir, w_inc_pc, w_load_pc;
    logic       w_alu_ena, w_load_acc, w_datactl_ena, w_hlt;
    logic [2:0] w_phase_next;

    assign w_op     = opcode_e'(opcode);
    assign w_mem_op = (w_op == OP_ADD) || (w_op == OP_ANDD) ||
                      (w_op == OP_XORR) || (w_op == OP_LDA);

    assign w_phase_next = (r_phase == 3'(PHASES - 1)) ? '0 : r_phase + 3'd1;

    // Decode the strobe row for the current phase from opcode and zero.
    always_comb begin
        w_rd          = 1'b0;
        w_wr          = 1'b0;
        w_load_ir     = 1'b0;
        w_inc_pc      = 1'b0;
        w_load_pc     = 1'b0;
        w_alu_ena     = 1'b0;
        w_load_acc    = 1'b0;
        w_datactl_ena = 1'b0;
        w_hlt         = 1'b0;
        case (r_phase)
            3'd0: begin
                w_rd      = 1'b1;
                w_load_ir = 1'b1;
            end
            3'd1: begin
                w_rd      = 1'b1;
                w_load_ir = 1'b1;
                w_inc_pc  = 1'b1;
            end
            3'd2: ;
            3'd3: begin
                w_inc_pc = 1'b1;
                w_hlt    = (w_op == OP_HLT);
            end
            3'd4: begin
                w_rd          = w_mem_op;
                w_datactl_ena = (w_op == OP_STO);
                w_load_pc     = (w_op == OP_JMP);
            end
            3'd5: begin
                w_rd          = w_mem_op;
                w_alu_ena     = w_mem_op;
                w_datactl_ena = (w_op == OP_STO);
                w_wr          = (w_op == OP_STO);
                w_load_pc     = (w_op == OP_JMP);
                w_inc_pc      = (w_op == OP_JMP) || ((w_op == OP_SKZ) && zero);
            end
            3'd6: begin
                w_load_acc    = w_mem_op;
                w_datactl_ena = (w_op == OP_STO);
            end
            3'd7: begin
                w_inc_pc = (w_op == OP_SKZ) && zero;
            end
            default: ;
        endcase
    end

    // Phase counter, halt state and registered strobe row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_phase       <= '0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_load_ir     <= 1'b0;
            r_inc_pc      <= 1'b0;
            r_load_pc     <= 1'b0;
            r_alu_ena     <= 1'b0;
            r_load_acc    <= 1'b0;
            r_datactl_ena <= 1'b0;
            r_halt        <= 1'b0;
        end else begin
            case (r_state)
                S_HALTED: begin
                    r_phase       <= 3'd4;
                    r_rd          <= 1'b0;
                    r_wr          <= 1'b0;
                    r_load_ir     <= 1'b0;
                    r_inc_pc      <= 1'b0;
                    r_load_pc     <= 1'b0;
                    r_alu_ena     <= 1'b0;
                    r_load_acc    <= 1'b0;
                    r_datactl_ena <= 1'b0;
                    r_halt        <= 1'b1;
                end
                default: begin
                    if (!ena) begin
                        r_phase       <= '0;
                        r_rd          <= 1'b0;
                        r_wr          <= 1'b0;
                        r_load_ir     <= 1'b0;
                        r_inc_pc      <= 1'b0;
                        r_load_pc     <= 1'b0;
                        r_alu_ena     <= 1'b0;
                        r_load_acc    <= 1'b0;
                        r_datactl_ena <= 1'b0;
                        r_halt        <= 1'b0;
                    end else begin
                        r_phase       <= w_phase_next;
                        r_rd          <= w_rd;
                        r_wr          <= w_wr;
                        r_load_ir     <= w_load_ir;
                        r_inc_pc      <= w_inc_pc;
                        r_load_pc     <= w_load_pc;
                        r_alu_ena     <= w_alu_ena;
                        r_load_acc    <= w_load_acc;
                        r_datactl_ena <= w_datactl_ena;
                        r_halt        <= w_hlt;
                        if (w_hlt) begin
                            r_state <= S_HALTED;
                        end
                    end
                end
            endcase
        end
    end

    assign rd          = r_rd;
    assign wr          = r_wr;
    assign load_ir     = r_load_ir;
    assign inc_pc      = r_inc_pc;
    assign load_pc     = r_load_pc;
    assign alu_ena     = r_alu_ena;
    assign load_acc    = r_load_acc;
    assign datactl_ena = r_datactl_ena;
    assign halt        = r_halt;
    assign phase       = r_phase;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed instruction sequences followed by
// randomized traffic, all compared against a behavioural model of the phase table.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt;
    logic [2:0] phase;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    int unsigned m_phase  = 0;
    bit          m_halted = 1'b0;
    logic [7:0]  m_row    = '0;
    int unsigned halt_cycles = 0;

    alu_sequencer #(.PHASES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .alu_ena     (alu_ena),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Row bits {rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena},
    // written per signal as the set of phases in which it fires.
    function automatic logic [7:0] exp_row(input int unsigned k, input logic [2:0] op, input logic z);
        bit mem, sto, jmp, skp;
        bit e_rd, e_wr, e_ir, e_inc, e_lpc, e_alu, e_acc, e_dctl;
        mem    = (op >= 3'd2) && (op <= 3'd5);
        sto    = (op == 3'd6);
        jmp    = (op == 3'd7);
        skp    = (op == 3'd1) && z;
        e_rd   = (k <= 1) || (mem && (k == 4 || k == 5));
        e_wr   = sto && (k == 5);
        e_ir   = (k <= 1);
        e_inc  = (k == 1) || (k == 3) || (jmp && k == 5) || (skp && (k == 5 || k == 7));
        e_lpc  = jmp && (k == 4 || k == 5);
        e_alu  = mem && (k == 5);
        e_acc  = mem && (k == 6);
        e_dctl = sto && (k >= 4) && (k <= 6);
        return {e_rd, e_wr, e_ir, e_inc, e_lpc, e_alu, e_acc, e_dctl};
    endfunction

    // Apply inputs for one edge, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] op, input logic z);
        rst_n  = r;
        ena    = e;
        opcode = op;
        zero   = z;
        @(posedge clk);
        if (!r) begin
            m_phase = 0; m_halted = 1'b0; m_row = '0;
        end else if (m_halted) begin
            m_phase = 4; m_row = '0;
        end else if (!e) begin
            m_phase = 0; m_row = '0;
        end else begin
            m_row = exp_row(m_phase, op, z);
            if (m_phase == 3 && op == 3'd0) m_halted = 1'b1;
            m_phase = (m_phase + 1) % 8;
        end
        #1;
        check_eq("outputs",
                 {halt, phase, rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena},
                 {m_halted, 3'(m_phase), m_row});
        check_eq("rd_and_wr", 32'(rd & wr), 32'd0);
        check_eq("wr_without_dctl", 32'(wr & ~datactl_ena), 32'd0);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, op, z);
    endtask

    logic [2:0] r_op;
    logic       r_e, r_r;

    initial begin
        rst_n = 1'b0; ena = 1'b0; opcode = '0; zero = 1'b0;

        // Reset then idle
        step(1'b0, 1'b1, 3'd2, 1'b0);
        step(1'b0, 1'b1, 3'd2, 1'b0);
        check_eq("reset_phase", 32'(phase), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd2, 1'b0);
        step(1'b1, 1'b1, 3'd2, 1'b0);
        check_eq("first_fetch_rd_ir", {30'd0, rd, load_ir}, 32'd3);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 3'd2, 1'b0);
        check_eq("add_wrap_phase", 32'(phase), 32'd0);

        run_instr(3'd2, 1'b0);   // ADD
        run_instr(3'd6, 1'b0);   // STO
        run_instr(3'd1, 1'b1);   // SKZ taken
        run_instr(3'd1, 1'b0);   // SKZ not taken
        run_instr(3'd7, 1'b0);   // JMP

        // HLT, then hold with ena toggling
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'd0, 1'b0);
        check_eq("halt_set", 32'(halt), 32'd1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'(i % 2), 3'($urandom), 1'($urandom));
        check_eq("halt_phase_frozen", 32'(phase), 32'd4);
        step(1'b0, 1'b1, 3'd2, 1'b0);
        check_eq("halt_cleared", {28'd0, halt, phase}, 32'd0);

        // LDA abandoned at phase 5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd5, 1'b0);
        step(1'b1, 1'b0, 3'd5, 1'b0);
        check_eq("abort_phase", 32'(phase), 32'd0);
        step(1'b1, 1'b1, 3'd5, 1'b0);
        step(1'b1, 1'b1, 3'd5, 1'b0);
        run_instr(3'd5, 1'b1);

        // Randomized traffic
        r_op = 3'd2;
        for (int i = 0; i < 3000; i++) begin
            if (m_phase == 0) r_op = ($urandom % 24 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            if (m_halted) halt_cycles++; else halt_cycles = 0;
            r_r = !((halt_cycles > 6) || ($urandom % 200 == 0));
            r_e = ($urandom % 12) != 0;
            step(r_r, r_e, r_op, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Instruction-phase controller for the 8-bit accumulator CPU core.
- Sequences each 2-byte instruction through a fixed 8-phase cycle: fetch, decode, operand read, ALU enable, accumulator load, store, PC update.
- Drives the memory strobes, IR/ACC/PC load enables and the ALU enable.
- Sits between the instruction register (supplies opcode), the ALU (supplies zero) and the memory/PC/accumulator datapath.

Parameters:
- PHASES, 8, number of phases per instruction; fixed at 8, phase counter is 3 bits.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- ena  input  1  run enable; 0 freezes the sequencer at phase 0 with all strobes low
- opcode  input  3  IR[7:5]: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111
- zero  input  1  accumulator-is-zero flag from ALU
- rd  output  1  memory read strobe
- wr  output  1  memory write strobe
- load_ir  output  1  instruction register load
- inc_pc  output  1  program counter increment
- load_pc  output  1  program counter load from IR address field
- alu_ena  output  1  ALU result register enable
- load_acc  output  1  accumulator load from ALU output
- datactl_ena  output  1  data bus driver enable (accumulator onto bus)
- halt  output  1  CPU halted, sticky
- phase  output  3  current phase number, for debug/trace

Behaviour:
- Reset: on rising edge with rst_n=0 (overrides everything, including mid-instruction and HALTED):
  - phase=0, halted state cleared.
  - All strobe outputs and halt = 0.
- Idle: ena=0 and not halted:
  - phase forced to 0, all strobes 0.
  - Resumes at phase 0 on the first edge with ena=1.
- Running: each rising edge with ena=1 and not halted:
  - Registers the output row for the current phase (decoded from opcode and zero sampled at that edge).
  - Advances phase to phase+1 mod 8.
  - Outputs are registered: row k is visible during the cycle after the edge at which phase==k.
- Row table (signals not listed are 0):
  - k=0: rd, load_ir (high byte)
  - k=1: rd, load_ir, inc_pc (low byte)
  - k=2: none (opcode settles; opcode must be stable from here to k=7)
  - k=3: inc_pc. If opcode=HLT, also halt, and the sequencer enters HALTED.
  - k=4: rd if ADD/ANDD/XORR/LDA; datactl_ena if STO; load_pc if JMP
  - k=5: rd and alu_ena if ADD/ANDD/XORR/LDA; datactl_ena and wr if STO; load_pc and inc_pc if JMP; inc_pc if SKZ and zero=1
  - k=6: load_acc if ADD/ANDD/XORR/LDA; datactl_ena if STO
  - k=7: inc_pc if SKZ and zero=1
- SKZ with zero=1 gives two inc_pc pulses, skipping the next 2-byte instruction. With zero=0 there are none.
- HALTED:
  - halt stays 1, all other strobes 0, phase holds at 4, ena ignored.
  - Exit only via rst_n=0.
- ena dropping mid-instruction: on that edge phase returns to 0 and strobes clear; the partial instruction is abandoned.
- Exclusivity invariants:
  - rd and wr never both 1.
  - wr=1 implies datactl_ena=1.
  - load_pc never 1 without opcode=JMP sampled in the row.

Test Plan:
- Reset/idle: rst_n=0 for 2 edges, then rst_n=1, ena=0 for 5 edges -> phase=0, all strobes 0 throughout. Then ena=1 -> first row shows rd=1, load_ir=1.
- ADD sequence: ena=1, opcode=010 for 8 edges -> rd in rows 0,1,4,5; alu_ena only in row 5; load_acc only in row 6; inc_pc in rows 1,3; phase wraps 7->0.
- STO sequence: opcode=110 -> datactl_ena in rows 4,5,6; wr=1 only in row 5; rd=0 in rows 2-7.
- SKZ: opcode=001, zero=1 -> inc_pc in rows 1,3,5,7 (4 pulses). Repeat with zero=0 -> inc_pc in rows 1,3 only.
- JMP then HLT: opcode=111 -> load_pc in rows 4,5. Next instruction opcode=000 -> halt=1 from row 3, phase frozen at 4, strobes 0 for 20 edges despite ena toggling. Then rst_n=0 -> halt=0, phase=0.
- Mid-instruction abort: LDA, drop ena at phase 5 -> next cycle all strobes 0, phase=0. Reassert ena -> clean fetch rows 0,1.
